// File: rtl/gemm_s2mm_if.sv
// Command, result-stream and memory-write signals of the GEMM stream-to-memory writer.
// slave is the writer's view; master is the controller/stream/memory side.
interface gemm_s2mm_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [WORD_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic                  s_tlast;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [WORD_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_ready;
    logic                  done;
    logic                  err_tlast;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len,
        input  s_tdata, s_tvalid, s_tlast,
        input  mem_wr_ready,
        output cmd_ready, s_tready,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output done, err_tlast
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len,
        output s_tdata, s_tvalid, s_tlast,
        output mem_wr_ready,
        input  cmd_ready, s_tready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  done, err_tlast
    );
endinterface

// File: rtl/gemm_s2mm.sv
// Writes cmd_len stream beats to consecutive word addresses from cmd_addr, flags tlast framing errors.
// Latency: beat accepted on edge M appears as a registered write from M+1; done pulses the cycle after the final write lands.
// Backpressure: s_tready follows mem_wr_ready combinationally, so a stalled write blocks the stream without loss.
module gemm_s2mm #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    gemm_s2mm_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } wr_req_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    wr_req_t               wr_q;
    logic                  wr_en_q;
    logic                  done_q;
    logic                  err_q;
    logic                  cmd_rdy_q;
    logic                  s_rdy;
    logic                  beat;
    logic                  wr_acc;

    // A new beat may overwrite the write register only when it is empty or being taken this cycle.
    assign s_rdy  = (state == RUN) && (!wr_en_q || bus.mem_wr_ready);
    assign beat   = bus.s_tvalid && s_rdy;
    assign wr_acc = wr_en_q && bus.mem_wr_ready;

    assign bus.s_tready    = s_rdy;
    assign bus.cmd_ready   = cmd_rdy_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = wr_q.addr;
    assign bus.mem_wr_data = wr_q.data;
    assign bus.done        = done_q;
    assign bus.err_tlast   = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            next_addr <= '0;
            remaining <= '0;
            wr_q      <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_rdy_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (wr_acc) begin
                wr_en_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        next_addr <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        cmd_rdy_q <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        wr_en_q   <= 1'b1;
                        wr_q      <= '{addr: next_addr, data: bus.s_tdata};
                        next_addr <= next_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        // Any framing mismatch still writes the beat; the rest of the frame is abandoned.
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                            err_q <= !bus.s_tlast;
                        end else if (bus.s_tlast) begin
                            state <= DRAIN;
                            err_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (wr_acc) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_rdy_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_s2mm.sv
// Scoreboard bench for gemm_s2mm: directed commands push expected writes, a negedge monitor checks them.
module tb_gemm_s2mm;
    localparam int WW = 32;
    localparam int AW = 16;
    localparam int LW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic          last;
        logic          err;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    gemm_s2mm_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    gemm_s2mm #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  checks = 0;
    int  fails = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  exp_done = 0;
    int  exp_err = 0;
    bit  done_due = 1'b0;
    bit  new_write = 1'b1;
    bit  zl_expect = 1'b0;
    int  rdy_mode = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input logic [AW-1:0] a, input logic [WW-1:0] d, input bit last, input bit err);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.last = last;
        e.err  = err;
        exp_q.push_back(e);
    endfunction

    // Memory-side ready: constant 1, or the stall pattern 1,0,0 repeating.
    initial begin
        int ph = 0;
        bus.mem_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                bus.mem_wr_ready = 1'b1;
            end else begin
                bus.mem_wr_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // Monitor: every visible write must match the queue head, and stay stable until accepted.
    always @(negedge clk) begin
        if (!reset_n) begin
            new_write = 1'b1;
            done_due  = 1'b0;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.err_tlast) err_cnt++;
            if (!zl_expect && (bus.done || done_due)) chk("done_timing", bus.done, done_due);
            done_due = 1'b0;
            if (bus.mem_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_en", bus.mem_wr_en, 0);
                    new_write = 1'b1;
                end else begin
                    chk("wr_addr", bus.mem_wr_addr, exp_q[0].addr);
                    chk("wr_data", bus.mem_wr_data, exp_q[0].data);
                    if (new_write) chk("err_tlast", bus.err_tlast, exp_q[0].err);
                    else if (bus.err_tlast) chk("err_tlast_extra", bus.err_tlast, 0);
                    if (!bus.mem_wr_ready) chk("s_tready_stall", bus.s_tready, 0);
                    if (bus.mem_wr_ready) begin
                        done_due = exp_q[0].last;
                        void'(exp_q.pop_front());
                        new_write = 1'b1;
                    end else begin
                        new_write = 1'b0;
                    end
                end
            end else begin
                new_write = 1'b1;
                if (bus.err_tlast) chk("err_tlast_idle", bus.err_tlast, 0);
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n = 0;
        bit acc = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        chk("cmd_accept", acc, 1);
    endtask

    task automatic send_beat(input logic [WW-1:0] d, input bit last, input int limit,
                             output bit acc, output int waits);
        bus.s_tdata  = d;
        bus.s_tlast  = last;
        bus.s_tvalid = 1'b1;
        acc   = 1'b0;
        waits = 0;
        while (!acc && waits < limit) begin
            @(negedge clk);
            acc = bus.s_tready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || done_due) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
        chk({tag, "_done_count"}, done_cnt, exp_done);
        chk({tag, "_err_count"}, err_cnt, exp_err);
    endtask

    initial begin
        bit acc;
        int w;
        int tot;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.s_tdata   = '0;
        bus.s_tvalid  = 1'b0;
        bus.s_tlast   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_wr_en", bus.mem_wr_en, 0);
        chk("rst_mem_wr_addr", bus.mem_wr_addr, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err_tlast, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_s_tready", bus.s_tready, 0);
        @(posedge clk);
        #1;

        // Basic, full throughput
        rdy_mode = 0;
        tot = 0;
        send_cmd(16'h0010, 16'd4);
        chk("basic_cmd_ready_busy", bus.cmd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            push(AW'(16'h0010 + i), WW'(32'hA0 + i), i == 3, 1'b0);
            send_beat(WW'(32'hA0 + i), i == 3, 20, acc, w);
            chk("basic_beat_acc", acc, 1);
            tot += w;
        end
        chk("basic_no_stall", tot, 0);
        exp_done++;
        wait_quiet("basic");

        // Backpressure
        rdy_mode = 1;
        send_cmd(16'h0010, 16'd4);
        for (int i = 0; i < 4; i++) begin
            push(AW'(16'h0010 + i), WW'(32'hB0 + i), i == 3, 1'b0);
            send_beat(WW'(32'hB0 + i), i == 3, 20, acc, w);
            chk("bp_beat_acc", acc, 1);
        end
        exp_done++;
        wait_quiet("bp");
        rdy_mode = 0;

        // Zero length
        zl_expect    = 1'b1;
        bus.s_tdata  = 32'hDEAD;
        bus.s_tvalid = 1'b1;
        send_cmd(16'h0100, 16'd0);
        @(negedge clk);
        chk("zl_done", bus.done, 1);
        chk("zl_s_tready_a", bus.s_tready, 0);
        @(negedge clk);
        chk("zl_done_low", bus.done, 0);
        chk("zl_cmd_ready", bus.cmd_ready, 1);
        chk("zl_s_tready_b", bus.s_tready, 0);
        @(posedge clk);
        #1;
        bus.s_tvalid = 1'b0;
        zl_expect    = 1'b0;
        exp_done++;
        wait_quiet("zl");

        // Early tlast on beat 2 of 4
        send_cmd(16'h0020, 16'd4);
        push(16'h0020, 32'hC0, 1'b0, 1'b0);
        send_beat(32'hC0, 1'b0, 20, acc, w);
        chk("early_b1", acc, 1);
        push(16'h0021, 32'hC1, 1'b1, 1'b1);
        send_beat(32'hC1, 1'b1, 20, acc, w);
        chk("early_b2", acc, 1);
        send_beat(32'hC2, 1'b0, 5, acc, w);
        chk("early_no_3rd", acc, 0);
        exp_done++;
        exp_err++;
        wait_quiet("early");

        // Missing tlast, len 2
        send_cmd(16'h0030, 16'd2);
        push(16'h0030, 32'hD0, 1'b0, 1'b0);
        send_beat(32'hD0, 1'b0, 20, acc, w);
        chk("miss_b1", acc, 1);
        push(16'h0031, 32'hD1, 1'b1, 1'b1);
        send_beat(32'hD1, 1'b0, 20, acc, w);
        chk("miss_b2", acc, 1);
        send_beat(32'hD2, 1'b0, 5, acc, w);
        chk("miss_no_3rd", acc, 0);
        exp_done++;
        exp_err++;
        wait_quiet("miss");

        // Address wrap
        send_cmd(16'hFFFF, 16'd3);
        push(16'hFFFF, 32'hE0, 1'b0, 1'b0);
        push(16'h0000, 32'hE1, 1'b0, 1'b0);
        push(16'h0001, 32'hE2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_beat(WW'(32'hE0 + i), i == 2, 20, acc, w);
            chk("wrap_beat_acc", acc, 1);
        end
        exp_done++;
        wait_quiet("wrap");

        // Reset after the 2nd beat of len 8; the 2nd write never lands
        send_cmd(16'h0040, 16'd8);
        push(16'h0040, 32'hF0, 1'b0, 1'b0);
        send_beat(32'hF0, 1'b0, 20, acc, w);
        chk("rr_b1", acc, 1);
        send_beat(32'hF1, 1'b0, 20, acc, w);
        chk("rr_b2", acc, 1);
        reset_n = 1'b0;
        #1;
        chk("rr_mem_wr_en", bus.mem_wr_en, 0);
        chk("rr_done", bus.done, 0);
        chk("rr_err", bus.err_tlast, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rr_cmd_ready", bus.cmd_ready, 1);
        chk("rr_queue_flushed", exp_q.size(), 0);
        @(posedge clk);
        #1;
        send_cmd(16'h0050, 16'd1);
        push(16'h0050, 32'h77, 1'b1, 1'b0);
        send_beat(32'h77, 1'b1, 20, acc, w);
        chk("rr_new_beat", acc, 1);
        exp_done++;
        wait_quiet("rr");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end
endmodule
